elm_weight_loader: RTL
======================

Name: elm_weight_loader

Overview:
- Streams a layer's trained weights and biases from an AXI-Stream-style slave input into the ELM neuron array.
- Drives the neuron load interface: a broadcast weight strobe tagged with layer and neuron numbers, and a per-neuron one-hot bias strobe.
- Sits between the AXI DMA/config front end and the neuron_<layer>_<n> instances of one layer.
- Guarantees exactly NUM_WEIGHT weight strobes per neuron, in neuron order.

Parameters:
DATA_W, 16, word width of weights, biases and stream data (matches `dataWidth).
NUM_WEIGHT, 128, weights per neuron.
NUM_NEURON, 30, neurons in the layer being loaded.
NEURON_BASE, 0, neuron number of the first neuron loaded.
CFG_W (localparam), 2*DATA_W+1, width of the config number outputs.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high, clock clk.
start  in  1  one-cycle pulse; begins a layer load; ignored while busy.
layer_no  in  CFG_W  layer number; sampled on an accepted start.
s_tvalid  in  1  stream word valid.
s_tdata  in  DATA_W  stream word, two's complement.
s_tlast  in  1  marks the final word of the layer image.
s_tready  out  1  stream ready.
weight_valid  out  1  weight strobe, broadcast to all neurons.
weight_value  out  DATA_W  weight word.
bias_valid  out  NUM_NEURON  one-hot bias strobe; bit i targets neuron NEURON_BASE+i.
bias_value  out  DATA_W  bias word.
config_layer_num  out  CFG_W  layer tag for weight strobes.
config_neuron_num  out  CFG_W  neuron tag for weight strobes.
busy  out  1  load in progress.
done  out  1  one-cycle pulse; load finished.
err  out  1  framing error; sticky until next accepted start.

Behaviour:
- Stream image per neuron: NUM_WEIGHT weight words, then 1 bias word. Neurons run NEURON_BASE upward. Total image = NUM_NEURON*(NUM_WEIGHT+1) words.
- Beat = s_tvalid & s_tready.
- s_tready = 1 only in LOAD_W and LOAD_B. It is decoded from the registered state, with no combinational path from s_tvalid.
- FSM states: IDLE, LOAD_W, LOAD_B, FINISH.
  - IDLE -> LOAD_W on start: latch layer_no; clear w_cnt, n_idx and err.
  - LOAD_W: each beat increments w_cnt. The beat with w_cnt==NUM_WEIGHT-1 moves to LOAD_B.
  - LOAD_B: a beat moves to LOAD_W with n_idx+1 and w_cnt=0. If n_idx==NUM_NEURON-1, it moves to FINISH instead.
  - FINISH -> IDLE after one cycle.
- Output timing: all outputs are registered, with 1-cycle latency from the beat.
  - A weight beat at cycle N gives weight_valid=1 at N+1, with weight_value=s_tdata, config_layer_num=latched layer, config_neuron_num=NEURON_BASE+n_idx.
  - A bias beat at cycle N gives bias_valid[n_idx]=1 at N+1 (all other bits 0), with bias_value=s_tdata.
- Hold rules:
  - config_layer_num and config_neuron_num hold their last values between strobes and after done, so neurons never see a tag glitch alongside a strobe.
  - weight_value and bias_value hold between strobes.
- Pacing: s_tvalid low stalls the load indefinitely. Strobes simply stop; there are no gaps in counting.
- done: pulses in the FINISH cycle, which is the same cycle as the final bias_valid.
- busy: high from the cycle after an accepted start through the done cycle inclusive.
- Framing:
  - s_tlast on any beat other than the final bias word: that word is still forwarded, then the FSM goes to FINISH. done pulses and err=1. Remaining neurons stay unloaded.
  - s_tlast low on the final bias word: load completes normally, with err=1.
- start while busy is ignored, including in the FINISH cycle.
- rst at any time:
  - FSM -> IDLE.
  - weight_valid, bias_valid, busy, done, err, s_tready -> 0.
  - weight_value, bias_value, config_layer_num, config_neuron_num -> 0.
  - Neuron write pointers are cleared by the same system rst, so a restarted load is consistent.
- No strobe is ever issued outside LOAD_W or LOAD_B beats.

Optional Feature:
WLOAD_CHECKSUM_EN
- Defined: adds output port checksum [DATA_W-1:0].
  - It is the modulo-2^DATA_W sum of every accepted word (weights and biases) since the last accepted start.
  - It is cleared on start and on rst.
  - It is final and stable from the done cycle until the next start.
- Undefined: the port and its adder are absent; all other behaviour is identical.

Test Plan (NUM_WEIGHT=4, NUM_NEURON=2, NEURON_BASE=0):
1. start with layer_no=1, then 10 back-to-back words 1..10 with tlast on word 10.
   -> weight_valid on 8 cycles: values 1-4 tagged neuron 0, values 6-9 tagged neuron 1, layer tag 1.
   -> bias_valid=2'b01 with value 5, then bias_valid=2'b10 with value 10.
   -> done coincident with the last bias_valid; err=0.
2. Same image with s_tvalid toggled 1/0 every cycle.
   -> Identical strobe sequence, one strobe per beat.
   -> config_neuron_num constant during each neuron's load.
3. tlast on word 3.
   -> 3 weight strobes for neuron 0, then done with err=1.
   -> No bias_valid.
   -> s_tready=0 after done.
4. Full image with tlast missing.
   -> Normal strobe sequence, done, err=1.
   -> Next start clears err.
5. rst asserted after word 6, then a new start and full image.
   -> All outputs 0 the cycle after rst.
   -> Second load matches scenario 1.
   -> A start pulse issued mid-load is ignored.
6. WLOAD_CHECKSUM_EN build with words 0xFFFF x10.
   -> checksum=0xFFF6 at done.

Source files
------------

// File: rtl/elm_weight_loader_if.sv
// Stream interface feeding the ELM weight loader.
// The master side is the DMA/config front end; the slave side is the loader.
interface elm_weight_loader_if #(
  parameter int DATA_W = 16
);
  logic              s_tvalid;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tlast;
  logic              s_tready;

  modport master (
    output s_tvalid,
    output s_tdata,
    output s_tlast,
    input  s_tready
  );

  modport slave (
    input  s_tvalid,
    input  s_tdata,
    input  s_tlast,
    output s_tready
  );
endinterface

// File: rtl/elm_weight_loader.sv
// ELM weight loader: streams one layer's weights and biases into the neuron
// array. Per neuron the image is NUM_WEIGHT weight words followed by one bias
// word, neurons in ascending order starting at NEURON_BASE.
// Optional build macro WLOAD_CHECKSUM_EN adds a running modulo-2^DATA_W
// checksum output over every accepted word of the current load.
//
// state  | meaning
// IDLE   | waiting for start, stream not ready
// LOAD_W | accepting weight words for neuron n_idx
// LOAD_B | accepting the bias word for neuron n_idx
// FINISH | one-cycle done pulse, then back to IDLE
module elm_weight_loader #(
  parameter int DATA_W      = 16,
  parameter int NUM_WEIGHT  = 128,
  parameter int NUM_NEURON  = 30,
  parameter int NEURON_BASE = 0,
  localparam int CFG_W      = 2*DATA_W+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CFG_W-1:0]      layer_no,
  elm_weight_loader_if.slave    s_axis,
  output logic                  weight_valid,
  output logic [DATA_W-1:0]     weight_value,
  output logic [NUM_NEURON-1:0] bias_valid,
  output logic [DATA_W-1:0]     bias_value,
  output logic [CFG_W-1:0]      config_layer_num,
  output logic [CFG_W-1:0]      config_neuron_num,
`ifdef WLOAD_CHECKSUM_EN
  output logic [DATA_W-1:0]     checksum,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NI_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam int WC_W = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, FINISH} state_t;

  state_t                state_q, state_d;
  logic [WC_W-1:0]       w_cnt_q, w_cnt_d;
  logic [NI_W-1:0]       n_idx_q, n_idx_d;
  logic [CFG_W-1:0]      layer_q, layer_d;
  logic                  err_q, err_d;
  logic                  weight_valid_q, weight_valid_d;
  logic [DATA_W-1:0]     weight_value_q, weight_value_d;
  logic [NUM_NEURON-1:0] bias_valid_q, bias_valid_d;
  logic [DATA_W-1:0]     bias_value_q, bias_value_d;
  logic [CFG_W-1:0]      cfg_layer_q, cfg_layer_d;
  logic [CFG_W-1:0]      cfg_neuron_q, cfg_neuron_d;
  logic                  beat;
  logic                  last_neuron;

  // Ready comes only from the registered state, never from s_tvalid.
  assign s_axis.s_tready = (state_q == LOAD_W) || (state_q == LOAD_B);
  assign beat            = s_axis.s_tvalid && s_axis.s_tready;
  assign last_neuron     = (n_idx_q == NI_W'(NUM_NEURON-1));

  // Next-state and registered strobe/tag computation.
  always_comb begin
    state_d        = state_q;
    w_cnt_d        = w_cnt_q;
    n_idx_d        = n_idx_q;
    layer_d        = layer_q;
    err_d          = err_q;
    weight_valid_d = 1'b0;
    weight_value_d = weight_value_q;
    bias_valid_d   = '0;
    bias_value_d   = bias_value_q;
    cfg_layer_d    = cfg_layer_q;
    cfg_neuron_d   = cfg_neuron_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          layer_d = layer_no;
          w_cnt_d = '0;
          n_idx_d = '0;
          err_d   = 1'b0;
        end
      end

      LOAD_W: begin
        if (beat) begin
          weight_valid_d = 1'b1;
          weight_value_d = s_axis.s_tdata;
          cfg_layer_d    = layer_q;
          cfg_neuron_d   = CFG_W'(NEURON_BASE) + CFG_W'(n_idx_q);
          if (s_axis.s_tlast) begin
            // early end of image: forward the word, then abort the load
            state_d = FINISH;
            err_d   = 1'b1;
          end else if (w_cnt_q == WC_W'(NUM_WEIGHT-1)) begin
            state_d = LOAD_B;
          end else begin
            w_cnt_d = w_cnt_q + WC_W'(1);
          end
        end
      end

      LOAD_B: begin
        if (beat) begin
          for (int i = 0; i < NUM_NEURON; i++) begin
            bias_valid_d[i] = (n_idx_q == NI_W'(i));
          end
          bias_value_d = s_axis.s_tdata;
          if (last_neuron) begin
            state_d = FINISH;
            err_d   = err_q | ~s_axis.s_tlast;
          end else if (s_axis.s_tlast) begin
            state_d = FINISH;
            err_d   = 1'b1;
          end else begin
            state_d = LOAD_W;
            n_idx_d = n_idx_q + NI_W'(1);
            w_cnt_d = '0;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      w_cnt_q        <= '0;
      n_idx_q        <= '0;
      layer_q        <= '0;
      err_q          <= 1'b0;
      weight_valid_q <= 1'b0;
      weight_value_q <= '0;
      bias_valid_q   <= '0;
      bias_value_q   <= '0;
      cfg_layer_q    <= '0;
      cfg_neuron_q   <= '0;
    end else begin
      state_q        <= state_d;
      w_cnt_q        <= w_cnt_d;
      n_idx_q        <= n_idx_d;
      layer_q        <= layer_d;
      err_q          <= err_d;
      weight_valid_q <= weight_valid_d;
      weight_value_q <= weight_value_d;
      bias_valid_q   <= bias_valid_d;
      bias_value_q   <= bias_value_d;
      cfg_layer_q    <= cfg_layer_d;
      cfg_neuron_q   <= cfg_neuron_d;
    end
  end

`ifdef WLOAD_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;

  // Running sum of accepted words, restarted by an accepted start.
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == IDLE) && start) begin
      checksum_d = '0;
    end else if (beat) begin
      checksum_d = checksum_q + s_axis.s_tdata;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  assign weight_valid      = weight_valid_q;
  assign weight_value      = weight_value_q;
  assign bias_valid        = bias_valid_q;
  assign bias_value        = bias_value_q;
  assign config_layer_num  = cfg_layer_q;
  assign config_neuron_num = cfg_neuron_q;
  assign busy              = (state_q != IDLE);
  assign done              = (state_q == FINISH);
  assign err               = err_q;

endmodule
